// File: rtl/reversible_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reversible_mux_arbiter_pkg
// Purpose  : Shared constants, FSM state type and Fredkin cell model for the
//            round-robin arbiter in front of the 4:1 Fredkin reversible mux.
// Revision : 1.0 - initial release
// ============================================================================
package reversible_mux_arbiter_pkg;

   localparam int c_num_req = 4;
   localparam int c_sel_w   = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Q output of a Fredkin (controlled-swap) cell: with c=0 the I1 input
   // passes straight through to Q, with c=1 the inputs swap and I2 appears.
   // Only Q is consumed by the mux tree; P and R are the garbage outputs.
   function automatic logic fredkin_q(input logic c, input logic i1, input logic i2);
      return c ? i2 : i1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reversible_mux_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : reversible_mux_arbiter_rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set bit of
//            cand scanning ptr, ptr+1, ... modulo 4, plus an any-set flag.
// Revision : 1.0 - initial release
// ============================================================================
module reversible_mux_arbiter_rr_pick
   import reversible_mux_arbiter_pkg::*;
(
   input  logic [c_num_req-1:0] cand,
   input  logic [c_sel_w-1:0]   ptr,
   output logic [c_sel_w-1:0]   pick,
   output logic                 any
);

   logic [c_sel_w-1:0] w_idx;

   // Scan from the farthest offset down so the nearest candidate to ptr wins.
   always_comb begin
      pick  = '0;
      w_idx = '0;
      any   = |cand;
      for (int i = c_num_req - 1; i >= 0; i--) begin
         w_idx = ptr + i[c_sel_w-1:0];
         if (cand[w_idx]) begin
            pick = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/reversible_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reversible_mux_arbiter
// Purpose  : Round-robin arbiter and burst sequencer sharing one 4:1 Fredkin
//            reversible mux between four serial requesters, with a registered
//            valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module reversible_mux_arbiter
   import reversible_mux_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int NUM_REQ   = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           req_i,
   input  logic [3:0]           data_i,
   input  logic [3:0]           last_i,
   input  logic [3:0]           mask_i,
   output logic [3:0]           accept_o,
   output logic [3:0]           gnt_o,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_data,
   output logic [c_sel_w-1:0]   out_src,
   output logic                 out_last
);

   // The datapath is a fixed 4:1 tree, so any other requester count is rejected.
   if (NUM_REQ != c_num_req) begin : g_num_req_bad
      $error("reversible_mux_arbiter: NUM_REQ must be 4");
   end
   if (MAX_BURST < 1) begin : g_max_burst_bad
      $error("reversible_mux_arbiter: MAX_BURST must be >= 1");
   end

   localparam int                 c_cnt_w   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_cap = c_cnt_w'(MAX_BURST - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

   state_t               r_state, w_state_nxt;
   logic [c_sel_w-1:0]   r_ptr, w_ptr_nxt;
   logic [c_sel_w-1:0]   r_sel, w_sel_nxt;
   logic [3:0]           r_gnt, w_gnt_nxt;
   logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;

   logic                 r_out_valid, r_out_data, r_out_last;
   logic [c_sel_w-1:0]   r_out_src;

   logic [3:0]           w_cand;
   logic [c_sel_w-1:0]   w_pick;
   logic                 w_any;
   logic                 w_req_g, w_fire, w_last;
   logic                 w_mux_lo, w_mux_hi, w_mux_q;

   assign w_cand = req_i & ~mask_i;

   reversible_mux_arbiter_rr_pick u_rr_pick (
      .cand (w_cand),
      .ptr  (r_ptr),
      .pick (w_pick),
      .any  (w_any)
   );

   // Two-level Fredkin tree: sel[0] steers the in0/in1 and in2/in3 cells,
   // sel[1] steers the final cell whose Q is the mux output.
   assign w_mux_lo = fredkin_q(r_sel[0], data_i[0], data_i[1]);
   assign w_mux_hi = fredkin_q(r_sel[0], data_i[2], data_i[3]);
   assign w_mux_q  = fredkin_q(r_sel[1], w_mux_lo, w_mux_hi);

   // A beat moves when the granted requester has one and the output stage can take it.
   assign w_req_g  = req_i[r_sel];
   assign w_fire   = (r_state == XFER) & w_req_g & (~r_out_valid | out_ready);
   assign w_last   = last_i[r_sel] | (r_cnt == c_cnt_cap);
   assign accept_o = w_fire ? (4'b0001 << r_sel) : 4'b0000;
   assign gnt_o    = r_gnt;

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_last  = r_out_last;

   // Arbitration state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_gnt   <= w_gnt_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: grant from IDLE, release on a last beat or on abandon.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = r_gnt;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = XFER;
               w_gnt_nxt   = 4'b0001 << w_pick;
               w_sel_nxt   = w_pick;
               w_cnt_nxt   = '0;
            end
         end
         XFER: begin
            if ((w_fire && w_last) || !w_req_g) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_ptr_nxt   = r_sel + 1'b1;
            end else if (w_fire) begin
               // The cap ends the grant before the counter could wrap.
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // Output register: load on fire, drain on ready, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 1'b0;
         r_out_src   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_fire) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_mux_q;
         r_out_src   <= r_sel;
         r_out_last  <= w_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reversible_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reversible_mux_arbiter
// Purpose  : Self-checking bench for reversible_mux_arbiter with a
//            transaction-level reference model of arbitration and bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reversible_mux_arbiter;

   localparam int MAX_BURST = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_i, data_i, last_i, mask_i;
   logic [3:0] accept_o, gnt_o;
   logic       out_valid, out_ready, out_data, out_last;
   logic [1:0] out_src;

   int checks = 0;
   int errors = 0;

   // Reference model state: current owner (-1 = none), rotation pointer,
   // beats in this grant, and the contents of the output register.
   int         m_owner, m_ptr, m_cnt, m_os;
   bit         m_ov, m_od, m_ol;
   logic [3:0] exp_acc, exp_gnt;

   always #5 clk = ~clk;

   reversible_mux_arbiter #(.MAX_BURST(MAX_BURST), .NUM_REQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .data_i    (data_i),
      .last_i    (last_i),
      .mask_i    (mask_i),
      .accept_o  (accept_o),
      .gnt_o     (gnt_o),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last)
   );

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_os = 0;
      m_ov = 0; m_od = 0; m_ol = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_i = '0; data_i = '0; last_i = '0; mask_i = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Drive one cycle of inputs mid-period and derive what the DUT should show.
   task automatic apply(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l,
                        input logic [3:0] m, input logic rdy);
      @(negedge clk);
      req_i = r; data_i = d; last_i = l; mask_i = m; out_ready = rdy;
      #1;
      exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      exp_acc = (m_owner >= 0 && req_i[m_owner] && (!m_ov || out_ready)) ? 4'(1 << m_owner) : 4'b0000;
   endtask

   // Advance the model across the clock edge using the held inputs.
   task automatic advance();
      bit         fire;
      bit         found;
      logic [3:0] cand;
      @(posedge clk);
      fire = (exp_acc != 0);
      if (m_owner < 0) begin
         if (out_ready) m_ov = 0;
         cand  = req_i & ~mask_i;
         found = 0;
         for (int i = 0; i < 4; i++) begin
            if (!found && cand[(m_ptr + i) % 4]) begin
               found   = 1;
               m_owner = (m_ptr + i) % 4;
               m_cnt   = 0;
            end
         end
      end else if (fire) begin
         m_od = data_i[m_owner];
         m_os = m_owner;
         m_ov = 1;
         m_ol = last_i[m_owner] || (m_cnt == MAX_BURST - 1);
         m_cnt++;
         if (m_ol) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1;
         end
      end else begin
         if (out_ready) m_ov = 0;
         if (!req_i[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_i = 4'hF; data_i = 4'hF; last_i = '0; mask_i = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({gnt_o, accept_o, out_valid, out_data, out_src, out_last} !== 12'd0) begin
         errors++;
         $display("FAIL reset_state gnt=%b acc=%b v=%b d=%b src=%0d last=%b, required all 0",
                  gnt_o, accept_o, out_valid, out_data, out_src, out_last);
      end
      do_reset();
   endtask

   task automatic test_single_req2();
      int left = 3, nbeats = 0, last_at = 0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         apply((left > 0) ? 4'b0100 : 4'b0000, 4'($urandom), (left == 1) ? 4'b0100 : 4'b0000, 4'b0000, 1'b1);
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL single_ctl gnt=%b acc=%b v=%b, required %b %b %b", gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         if (m_ov) begin
            checks++;
            if ({out_data, out_src, out_last} !== {m_od, 2'(m_os), m_ol}) begin
               errors++;
               $display("FAIL single_beat d=%b src=%0d last=%b, required %b %0d %b", out_data, out_src, out_last, m_od, m_os, m_ol);
            end
         end
         if (out_valid && out_ready) begin
            nbeats++;
            if (out_last) last_at = nbeats;
         end
         if (accept_o[2]) left--;
         advance();
      end
      checks++;
      if (nbeats != 3 || last_at != 3) begin
         errors++;
         $display("FAIL single_count beats=%0d last_at=%0d, required 3 and 3", nbeats, last_at);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int want[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         apply(4'hF, 4'($urandom), 4'hF, 4'h0, 1'b1);
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL rr_ctl gnt=%b acc=%b v=%b, required %b %b %b", gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         for (int k = 0; k < 4; k++) if (gnt_o == 4'(1 << k)) order.push_back(k);
         advance();
      end
      checks++;
      if (order.size() != 5) begin
         errors++;
         $display("FAIL rr_len grants=%0d, required 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != want[i]) begin
               errors++;
               $display("FAIL rr_order grant[%0d]=%0d, required %0d", i, order[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_burst_cap();
      int   src1 = 0, last_at = 0;
      bit   seen1 = 0;
      logic [3:0] next_g = '0;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         apply(4'b0110, 4'($urandom), 4'b0000, 4'b0000, 1'b1);
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL cap_ctl gnt=%b acc=%b v=%b, required %b %b %b", gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         if (m_ov) begin
            checks++;
            if ({out_data, out_src, out_last} !== {m_od, 2'(m_os), m_ol}) begin
               errors++;
               $display("FAIL cap_beat d=%b src=%0d last=%b, required %b %0d %b", out_data, out_src, out_last, m_od, m_os, m_ol);
            end
         end
         if (out_valid && out_src == 2'd1) begin
            src1++;
            if (out_last && last_at == 0) last_at = src1;
         end
         if (gnt_o == 4'b0010) seen1 = 1;
         else if (seen1 && gnt_o != 4'b0000 && next_g == 4'b0000) next_g = gnt_o;
         advance();
      end
      checks++;
      if (src1 != MAX_BURST || last_at != MAX_BURST || next_g != 4'b0100) begin
         errors++;
         $display("FAIL cap_release beats=%0d last_at=%0d next_gnt=%b, required 8 8 0100", src1, last_at, next_g);
      end
   endtask

   task automatic test_backpressure();
      int   left = 6, nbeats = 0, nlast = 0, stall_acc = 0;
      logic rdy;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         rdy = !(c >= 5 && c <= 9);
         apply((left > 0) ? 4'b1000 : 4'b0000, 4'($urandom), (left == 1) ? 4'b1000 : 4'b0000, 4'b0000, rdy);
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL bp_ctl gnt=%b acc=%b v=%b, required %b %b %b", gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         if (m_ov) begin
            checks++;
            if ({out_data, out_src, out_last} !== {m_od, 2'(m_os), m_ol}) begin
               errors++;
               $display("FAIL bp_beat d=%b src=%0d last=%b, required %b %0d %b", out_data, out_src, out_last, m_od, m_os, m_ol);
            end
         end
         if (!rdy && accept_o != 0) stall_acc++;
         if (out_valid && out_ready) begin
            nbeats++;
            if (out_last) nlast++;
         end
         if (accept_o[3]) left--;
         advance();
      end
      checks++;
      if (stall_acc != 0 || nbeats != 6 || nlast != 1) begin
         errors++;
         $display("FAIL bp_total stall_acc=%0d beats=%0d lasts=%0d, required 0 6 1", stall_acc, nbeats, nlast);
      end
   endtask

   task automatic test_mask();
      int acc0 = 0, acc1 = 0;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         apply(4'b0011, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 4'b0011 : 4'b0000), 4'b0001, 1'($urandom_range(0, 3) != 0));
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL mask_ctl gnt=%b acc=%b v=%b, required %b %b %b", gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         if (accept_o[0]) acc0++;
         if (accept_o[1]) acc1++;
         advance();
      end
      checks++;
      if (acc0 != 0 || acc1 == 0) begin
         errors++;
         $display("FAIL mask_accepts req0=%0d req1=%0d, required 0 and >0", acc0, acc1);
      end
   endtask

   task automatic test_random();
      logic [3:0] r = '0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 4; k++) if ($urandom_range(0, 4) == 0) r[k] = ~r[k];
         apply(r, 4'($urandom), 4'($urandom) & 4'($urandom),
               ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000, 1'($urandom_range(0, 3) != 0));
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL rand_ctl cyc=%0d gnt=%b acc=%b v=%b, required %b %b %b", c, gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         if (m_ov) begin
            checks++;
            if ({out_data, out_src, out_last} !== {m_od, 2'(m_os), m_ol}) begin
               errors++;
               $display("FAIL rand_beat cyc=%0d d=%b src=%0d last=%b, required %b %0d %b", c, out_data, out_src, out_last, m_od, m_os, m_ol);
            end
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         apply(4'b1000, 4'($urandom), 4'b0000, 4'b0000, 1'b1);
         advance();
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt_o, accept_o, out_valid, out_data, out_src, out_last} !== 12'd0) begin
         errors++;
         $display("FAIL async_reset gnt=%b acc=%b v=%b d=%b src=%0d last=%b, required all 0",
                  gnt_o, accept_o, out_valid, out_data, out_src, out_last);
      end
      model_reset();
      @(negedge clk);
      req_i = '0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         apply(4'hF, 4'($urandom), 4'h0, 4'h0, 1'b1);
         checks++;
         if ({gnt_o, accept_o, out_valid} !== {exp_gnt, exp_acc, m_ov}) begin
            errors++;
            $display("FAIL post_reset_ctl gnt=%b acc=%b v=%b, required %b %b %b", gnt_o, accept_o, out_valid, exp_gnt, exp_acc, m_ov);
         end
         if (c == 1) begin
            checks++;
            if (gnt_o !== 4'b0001) begin
               errors++;
               $display("FAIL post_reset_ptr gnt=%b, required 0001", gnt_o);
            end
         end
         advance();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_req2();
      test_round_robin();
      test_burst_cap();
      test_backpressure();
      test_mask();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
